// File: rtl/sfr_write_arbiter.sv
// Shares the single SFR write path among N_REQ requesters (CPU priority, round-robin, lock).
// Optional: define SFR_ARB_TIMEOUT_EN to force-release a lock after LOCK_MAX cycles.
module sfr_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int CPU_PRIO = 1,
  parameter int LOCK_MAX = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ-1:0]   i_lock,
  input  logic [8*N_REQ-1:0] i_addr,
  input  logic [8*N_REQ-1:0] i_data,
  output logic [N_REQ-1:0]   o_gnt,
  output logic               o_wr_en,
  output logic [7:0]         o_wr_addr,
  output logic [7:0]         o_wr_data,
  output logic               o_locked,
  output logic               o_timeout
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOCK} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d, rr_q, rr_d;
  logic             lock_cap_q, lock_cap_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             wr_en_q, wr_en_d;
  logic             locked_q, locked_d;
  logic [7:0]       addr_q, addr_d, data_q, data_d;

`ifdef SFR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_MAX + 2) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // Round-robin pick: scan downward so the nearest port after rr_q is written last.
  logic [N_REQ-1:0] elig;
  logic [PW-1:0]    rr_win;
  always_comb begin
    int idx;
    elig = i_req;
    if (CPU_PRIO != 0) elig[0] = 1'b0;
    rr_win = '0;
    idx    = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (elig[idx]) rr_win = idx[PW-1:0];
    end
  end

  always_comb begin
    int   w;
    logic take;
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    lock_cap_d = lock_cap_q;
    gnt_d      = '0;
    wr_en_d    = 1'b0;
    locked_d   = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    take       = 1'b0;
    w          = int'(owner_q);
`ifdef SFR_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          take = 1'b1;
          if (CPU_PRIO != 0 && i_req[0]) begin
            w = 0;
          end else begin
            w    = int'(rr_win);
            rr_d = rr_win;
          end
        end
      end
      S_ISSUE: begin
        if (lock_cap_q) begin
          state_d  = S_LOCK;
          locked_d = 1'b1;
`ifdef SFR_ARB_TIMEOUT_EN
          cnt_d = locked_q ? cnt_q + CW'(1) : CW'(1);
`endif
        end else begin
          state_d = S_IDLE;
`ifdef SFR_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      S_LOCK: begin
`ifdef SFR_ARB_TIMEOUT_EN
        if (cnt_q >= CW'(LOCK_MAX)) begin
          // Forced release; rr_q already points at the owner so others go first.
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else if (i_req[owner_q]) begin
          take     = 1'b1;
          locked_d = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
`else
        if (i_req[owner_q]) begin
          take     = 1'b1;
          locked_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      state_d    = S_ISSUE;
      owner_d    = w[PW-1:0];
      gnt_d[w]   = 1'b1;
      wr_en_d    = 1'b1;
      addr_d     = i_addr[8*w +: 8];
      data_d     = i_data[8*w +: 8];
      lock_cap_d = i_lock[w];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      lock_cap_q <= 1'b0;
      gnt_q      <= '0;
      wr_en_q    <= 1'b0;
      locked_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
`ifdef SFR_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      lock_cap_q <= lock_cap_d;
      gnt_q      <= gnt_d;
      wr_en_q    <= wr_en_d;
      locked_q   <= locked_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
`ifdef SFR_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign o_gnt     = gnt_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = addr_q;
  assign o_wr_data = data_q;
  assign o_locked  = locked_q;
`ifdef SFR_ARB_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sfr_write_arbiter.sv
// Directed bench for sfr_write_arbiter: reset, CPU priority, round-robin, lock, timeout, async reset.
module tb_sfr_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, lock;
  logic [31:0] addr, data;
  logic [3:0]  gnt;
  logic        wr_en, locked, timeout;
  logic [7:0]  wr_addr, wr_data;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  sfr_write_arbiter #(.N_REQ(4), .CPU_PRIO(1), .LOCK_MAX(4)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_req(req), .i_lock(lock),
    .i_addr(addr), .i_data(data), .o_gnt(gnt), .o_wr_en(wr_en),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_locked(locked), .o_timeout(timeout)
  );

  // Handshake monitor: addr/data must not move while req is held without a grant.
  logic [3:0]  gnt_mid = '0, req_prev = '0;
  logic [31:0] addr_prev = '0, data_prev = '0;
  int viol = 0;
  always @(negedge clk) gnt_mid = gnt;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (req_prev[i] && req[i] && !gnt_mid[i] &&
          (addr[i*8 +: 8] !== addr_prev[i*8 +: 8] || data[i*8 +: 8] !== data_prev[i*8 +: 8]))
        viol++;
    req_prev  = req;
    addr_prev = addr;
    data_prev = data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic exp_issue(input string tag, input logic [3:0] g, input logic [7:0] a,
                           input logic [7:0] d, input logic lk);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_wen"}, 32'(wr_en), 32'd1);
    chk({tag, "_addr"}, 32'(wr_addr), 32'(a));
    chk({tag, "_data"}, 32'(wr_data), 32'(d));
    chk({tag, "_lck"}, 32'(locked), 32'(lk));
  endtask

  task automatic exp_quiet(input string tag, input logic lk);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_wen"}, 32'(wr_en), 32'd0);
    chk({tag, "_lck"}, 32'(locked), 32'(lk));
  endtask

  task automatic set_port(input int p, input logic [7:0] a, input logic [7:0] d, input logic l);
    addr[p*8 +: 8] = a;
    data[p*8 +: 8] = d;
    lock[p]        = l;
  endtask

  initial begin
    // 1: reset with all requesting, then CPU first, then 1,2,3 in order
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    addr  = 32'h83828180;
    data  = 32'h33221100;
    cyc(); cyc();
    exp_quiet("rst", 1'b0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_tmo", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    cyc(); exp_issue("rst_cpu", 4'b0001, 8'h80, 8'h00, 1'b0); req = 4'b1110;
    cyc(); exp_quiet("gap0", 1'b0); chk("hold_addr", 32'(wr_addr), 32'h80);
    cyc(); exp_issue("seq_p1", 4'b0010, 8'h81, 8'h11, 1'b0); req = 4'b1100;
    cyc(); cyc(); exp_issue("seq_p2", 4'b0100, 8'h82, 8'h22, 1'b0); req = 4'b1000;
    cyc(); cyc(); exp_issue("seq_p3", 4'b1000, 8'h83, 8'h33, 1'b0); req = 4'b0000;
    cyc();

    // 3: continuous round-robin 1,2,3,1 then CPU preempts
    set_port(1, 8'hA1, 8'hB1, 1'b0);
    set_port(2, 8'hA2, 8'hB2, 1'b0);
    set_port(3, 8'hA3, 8'hB3, 1'b0);
    req = 4'b1110;
    cyc(); exp_issue("rr1", 4'b0010, 8'hA1, 8'hB1, 1'b0);
    cyc(); exp_quiet("rr_gap", 1'b0);
    cyc(); exp_issue("rr2", 4'b0100, 8'hA2, 8'hB2, 1'b0);
    cyc(); cyc(); exp_issue("rr3", 4'b1000, 8'hA3, 8'hB3, 1'b0);
    cyc(); cyc(); exp_issue("rr4", 4'b0010, 8'hA1, 8'hB1, 1'b0);
    set_port(0, 8'hE0, 8'hF0, 1'b0);
    req = 4'b1111;
    cyc(); cyc(); exp_issue("cpu_pre", 4'b0001, 8'hE0, 8'hF0, 1'b0);
    req = 4'b0000;
    cyc();

    // 2: single write from port 2
    set_port(2, 8'h88, 8'h10, 1'b0);
    req = 4'b0100;
    cyc(); exp_issue("single", 4'b0100, 8'h88, 8'h10, 1'b0); req = 4'b0000;
    cyc();

    // 4: locked two-byte burst from port 3 while port 1 waits
    set_port(3, 8'h8C, 8'hA5, 1'b1);
    set_port(1, 8'h11, 8'h77, 1'b0);
    req = 4'b1010;
    cyc(); exp_issue("lk_w1", 4'b1000, 8'h8C, 8'hA5, 1'b0);
    set_port(3, 8'h8A, 8'h5A, 1'b0);
    cyc(); exp_quiet("lk_hold", 1'b1);
    cyc(); exp_issue("lk_w2", 4'b1000, 8'h8A, 8'h5A, 1'b1); req = 4'b0010;
    cyc(); exp_quiet("lk_rel", 1'b0);
    cyc(); exp_issue("lk_p1", 4'b0010, 8'h11, 8'h77, 1'b0); req = 4'b0000;
    cyc();

    // 5: port 2 holds lock and req continuously
    set_port(2, 8'h8B, 8'h01, 1'b1);
    set_port(1, 8'h12, 8'h02, 1'b0);
    req = 4'b0110;
    cyc(); exp_issue("to_w1", 4'b0100, 8'h8B, 8'h01, 1'b0);
    cyc(); exp_quiet("to_l1", 1'b1);
    cyc(); exp_issue("to_w2", 4'b0100, 8'h8B, 8'h01, 1'b1);
    cyc(); exp_quiet("to_l2", 1'b1);
    cyc(); exp_issue("to_w3", 4'b0100, 8'h8B, 8'h01, 1'b1);
    cyc(); exp_quiet("to_l3", 1'b1); chk("to_nopulse", 32'(timeout), 32'd0);
`ifdef SFR_ARB_TIMEOUT_EN
    cyc(); exp_quiet("to_rel", 1'b0); chk("to_pulse", 32'(timeout), 32'd1);
    req = 4'b0010; lock = 4'b0000;
    cyc(); exp_issue("to_p1", 4'b0010, 8'h12, 8'h02, 1'b0); chk("to_end", 32'(timeout), 32'd0);
    req = 4'b0000;
`else
    cyc(); exp_issue("to_w4", 4'b0100, 8'h8B, 8'h01, 1'b1); chk("to_none", 32'(timeout), 32'd0);
    req = 4'b0010; lock = 4'b0000;
    cyc(); exp_quiet("to_l4", 1'b1);
    cyc(); exp_quiet("to_rel", 1'b0);
    cyc(); exp_issue("to_p1", 4'b0010, 8'h12, 8'h02, 1'b0);
    req = 4'b0000;
`endif
    cyc();

    // 6: async reset asserted during an ISSUE inside a lock
    set_port(3, 8'h9C, 8'h66, 1'b1);
    req = 4'b1000;
    cyc(); exp_issue("ar_w1", 4'b1000, 8'h9C, 8'h66, 1'b0);
    cyc(); exp_quiet("ar_lk", 1'b1);
    cyc(); exp_issue("ar_w2", 4'b1000, 8'h9C, 8'h66, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    exp_quiet("ar_kill", 1'b0);
    chk("ar_addr", 32'(wr_addr), 32'd0);
    req  = 4'b0000;
    lock = 4'b0000;
    cyc(); rst_n = 1'b1;
    cyc(); exp_quiet("ar_idle", 1'b0);
    set_port(1, 8'h21, 8'h43, 1'b0);
    req = 4'b0010;
    cyc(); exp_issue("ar_p1", 4'b0010, 8'h21, 8'h43, 1'b0); req = 4'b0000;
    cyc();
    chk("handshake", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
